uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//   8N1 UART receiver, LSB first. Pairs with the 9600-baud transmitter on the same board.
//   Synchronises the asynchronous rx line and validates the start bit at mid-bit.
//   Samples 8 data bits at bit centres and checks the stop bit.
//   Presents each received byte with a one-cycle valid pulse, or flags a framing error.
// PARAMETERS
//   CLKS_PER_BIT  5208  clk cycles per bit period (50 MHz / 9600 baud); legal range >= 4
//   HALF_BIT      (CLKS_PER_BIT-1)/2  derived (localparam); cycles from start entry to start-bit centre
// PORTS
//   clk        in   1  system clock, all logic on posedge
//   rst_l      in   1  synchronous reset, active low
//   rx         in   1  serial line, asynchronous, idles high
//   d_out      out  8  last good byte; holds until next good frame
//   valid      out  1  one-cycle pulse: d_out updated this cycle
//   frame_err  out  1  one-cycle pulse: stop bit sampled low
//   busy       out  1  high in every state except IDLE
// BEHAVIOUR
//   Reset (rst_l==0 at posedge, overrides everything, including mid-frame):
//     state=IDLE, d_out=8'h00, valid=0, frame_err=0, busy=0, counters=0.
//     Both synchroniser flops=1.
//   Input sync: rx -> 2 flops -> rx_s; 2-cycle latency. Only rx_s is used internally.
//   Counter cnt: width $clog2(CLKS_PER_BIT). bit_idx: 3 bits. shift: 8 bits.
//   valid and frame_err default to 0 every cycle; they are never high together.
//   FSM:
//     IDLE  : rx_s==0 -> START, cnt=0. Otherwise stay.
//     START : cnt++ each cycle.
//             At cnt==HALF_BIT: if rx_s==0 -> DATA, cnt=0, bit_idx=0.
//             Else (glitch) -> IDLE, no output pulse.
//     DATA  : cnt++ each cycle.
//             At cnt==CLKS_PER_BIT-1: shift[bit_idx]<=rx_s, cnt=0.
//             If bit_idx==7 -> STOP, else bit_idx++.
//     STOP  : cnt++ each cycle. At cnt==CLKS_PER_BIT-1:
//             rx_s==1 -> d_out<=shift, valid<=1, -> IDLE.
//             rx_s==0 -> frame_err<=1, d_out unchanged, -> BREAK.
//     BREAK : wait for rx_s==1 -> IDLE. Prevents a held-low line from retriggering.
//   Timing: START is entered at edge E0.
//     Data bit k is sampled at E0+HALF_BIT+(k+1)*CLKS_PER_BIT.
//     The stop bit is sampled, and valid/frame_err asserted, at E0+HALF_BIT+9*CLKS_PER_BIT.
//   Back-to-back frames: IDLE re-arms on the cycle after valid.
//     A start edge arriving half a bit after the stop centre must be captured.
//   No flow control: each new good frame overwrites d_out. The consumer latches on valid.
//   rx toggling during DATA/STOP between sample points is ignored.
// TESTING (CLKS_PER_BIT=16 for simulation)
//   1) Reset, rx=1 for 100 cycles.
//      -> d_out=00, valid/frame_err/busy never high.
//   2) Send frame 0xA5 (bits 1,0,1,0,0,1,0,1 LSB first, stop=1).
//      -> exactly one valid pulse, d_out=8'hA5, busy low afterwards.
//   3) Send 0x3C then immediately 0xC3 with no idle gap.
//      -> two valid pulses, d_out=3C then C3, no frame_err.
//   4) rx low for 4 cycles, then high.
//      -> START aborts, back to IDLE, no valid/frame_err.
//   5) Send 0x55 with stop bit=0, then hold rx low 40 cycles, then high.
//      -> one frame_err pulse, d_out keeps prior value, no second frame_err.
//      -> next 0x81 frame is received correctly.
//   6) Assert rst_l=0 for 1 cycle during DATA of 0xFF.
//      -> outputs at reset values next cycle, no valid.
//      -> following 0x0F frame received as 0x0F.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first: two-flop input synchroniser, mid-bit start
// validation, centre sampling of data/stop bits, valid or framing-error pulse.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       rst_l,
    input  logic       rx,
    output logic [7:0] d_out,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned HALF_BIT = (CLKS_PER_BIT - 1) / 2;
    localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       d_out_q, d_out_d;
    logic             valid_q, valid_d;
    logic             frame_err_q, frame_err_d;
    logic             busy_q, busy_d;
    logic             rx_meta_q, rx_s_q;

    // State and output registers; synchroniser resets to the idle (high) level.
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            d_out_q     <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            d_out_q     <= d_out_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
            rx_meta_q   <= rx;
            rx_s_q      <= rx_meta_q;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        d_out_d     = d_out_q;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d              = '0;
                    shift_d[bit_idx_q] = rx_s_q;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        d_out_d = shift_q;
                        valid_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_BREAK: begin
                // A line held low after a bad stop bit must not look like a new start.
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign d_out     = d_out_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame table plus hand-built corner sequences,
// with a byte scoreboard drained on every valid pulse.
module tb_uart_rx;

    localparam int unsigned CPB = 16;

    logic       clk;
    logic       rst_l;
    logic       rx;
    logic [7:0] d_out;
    logic       valid;
    logic       frame_err;
    logic       busy;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst_l     (rst_l),
        .rx        (rx),
        .d_out     (d_out),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_total;
    int unsigned n_pass;
    int unsigned valid_cnt;
    int unsigned ferr_cnt;
    logic        any_high;
    logic [7:0]  exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Scoreboard: every valid pulse must match the oldest outstanding byte.
    always @(negedge clk) begin
        if (valid || frame_err || busy) any_high = 1'b1;
        if (valid && frame_err) chk("valid_and_ferr", 32'(1), 32'(0));
        if (frame_err) ferr_cnt++;
        if (valid) begin
            valid_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 32'(d_out), 32'hFFFF_FFFF);
            end else begin
                chk("sb_byte", 32'(d_out), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic idle(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_bit);
        if (stop_bit) exp_q.push_back(data);
        rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            idle(CPB);
        end
        rx = stop_bit;
        idle(CPB);
    endtask

    typedef struct {
        logic [7:0]  data;
        logic        stop_bit;
        int unsigned gap;
        logic [7:0]  exp_dout;
    } vec_t;

    vec_t vecs[3];

    initial begin
        int unsigned v0;
        int unsigned f0;

        vecs[0] = '{data: 8'hA5, stop_bit: 1'b1, gap: 20, exp_dout: 8'hA5};
        vecs[1] = '{data: 8'h3C, stop_bit: 1'b1, gap: 0,  exp_dout: 8'h3C};
        vecs[2] = '{data: 8'hC3, stop_bit: 1'b1, gap: 20, exp_dout: 8'hC3};

        n_total   = 0;
        n_pass    = 0;
        valid_cnt = 0;
        ferr_cnt  = 0;
        rx        = 1'b1;
        rst_l     = 1'b0;
        idle(3);
        rst_l    = 1'b1;
        any_high = 1'b0;
        @(negedge clk);
        chk("rst_dout",  32'(d_out),     32'(8'h00));
        chk("rst_valid", 32'(valid),     32'(0));
        chk("rst_ferr",  32'(frame_err), 32'(0));
        chk("rst_busy",  32'(busy),      32'(0));

        // Idle line for 100 cycles: nothing may stir.
        idle(100);
        chk("idle_quiet", 32'(any_high), 32'(0));
        chk("idle_dout",  32'(d_out),    32'(8'h00));

        // Frame table, including back-to-back 0x3C/0xC3.
        f0 = ferr_cnt;
        for (int i = 0; i < 3; i++) begin
            v0 = valid_cnt;
            send_frame(vecs[i].data, vecs[i].stop_bit);
            rx = 1'b1;
            idle(vecs[i].gap);
            chk($sformatf("vec%0d_valid_pulses", i), 32'(valid_cnt - v0), 32'(1));
            chk($sformatf("vec%0d_dout", i), 32'(d_out), 32'(vecs[i].exp_dout));
        end
        chk("table_busy_after", 32'(busy),           32'(0));
        chk("table_no_ferr",    32'(ferr_cnt - f0),  32'(0));

        // Short low glitch: start aborts silently.
        v0 = valid_cnt;
        f0 = ferr_cnt;
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(30);
        chk("glitch_valid", 32'(valid_cnt - v0), 32'(0));
        chk("glitch_ferr",  32'(ferr_cnt - f0),  32'(0));
        chk("glitch_busy",  32'(busy),           32'(0));
        chk("glitch_dout",  32'(d_out),          32'(8'hC3));

        // Bad stop bit then line held low: one error, BREAK holds off retrigger.
        v0 = valid_cnt;
        f0 = ferr_cnt;
        send_frame(8'h55, 1'b0);
        idle(40);
        chk("break_busy", 32'(busy), 32'(1));
        rx = 1'b1;
        idle(20);
        chk("ferr_pulses", 32'(ferr_cnt - f0),  32'(1));
        chk("ferr_valid",  32'(valid_cnt - v0), 32'(0));
        chk("ferr_dout",   32'(d_out),          32'(8'hC3));
        chk("ferr_busy",   32'(busy),           32'(0));
        send_frame(8'h81, 1'b1);
        rx = 1'b1;
        idle(20);
        chk("post_ferr_dout", 32'(d_out), 32'(8'h81));

        // Reset pulse in the middle of the data bits of 0xFF.
        v0 = valid_cnt;
        rx = 1'b0;
        idle(CPB);
        rx = 1'b1;
        idle(3 * CPB);
        chk("mid_busy", 32'(busy), 32'(1));
        rst_l = 1'b0;
        @(negedge clk);
        rst_l = 1'b1;
        chk("mrst_dout",  32'(d_out),     32'(8'h00));
        chk("mrst_valid", 32'(valid),     32'(0));
        chk("mrst_ferr",  32'(frame_err), 32'(0));
        chk("mrst_busy",  32'(busy),      32'(0));
        idle(6 * CPB);
        chk("mrst_no_valid", 32'(valid_cnt - v0), 32'(0));
        send_frame(8'h0F, 1'b1);
        rx = 1'b1;
        idle(20);
        chk("post_rst_dout", 32'(d_out), 32'(8'h0F));

        chk("sb_drained",  32'(exp_q.size()), 32'(0));
        chk("total_valid", 32'(valid_cnt),    32'(5));
        chk("total_ferr",  32'(ferr_cnt),     32'(1));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
